// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the MiniRiscV core.
// Runs one load or store per request over a req/ack data-memory port.
// Faults (illegal funct3, misalignment, timeout) complete without touching memory.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [31:0]           ALUResult,
    input  logic [31:0]           ReadData2,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic [1:0]            fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] F_OK    = 2'b00;
    localparam logic [1:0] F_ALIGN = 2'b01;
    localparam logic [1:0] F_ILL   = 2'b10;
    localparam logic [1:0] F_TMO   = 2'b11;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_off;
    logic [2:0]            r_funct3;
    logic                  r_is_load;
    logic [31:0]           r_load_data;
    logic [1:0]            r_fault;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [3:0]            r_mem_be;

    logic                  w_start;
    logic                  w_illegal;
    logic                  w_misaligned;
    logic [31:0]           w_st_wdata;
    logic [3:0]            w_st_be;
    logic [31:0]           w_ld_fmt;
    logic                  w_unused_addr;

    // Upper address bits wrap around and are deliberately not decoded.
    assign w_unused_addr = ^ALUResult[31:ADDR_WIDTH+2];

    assign w_start = req_valid & (MemRead | MemWrite) & (r_state == S_IDLE);

    // Classify the incoming request: legal funct3 set differs for stores and loads.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (MemWrite) begin
            w_illegal = funct3[2] | (funct3[1] & funct3[0]);
        end else begin
            w_illegal = (funct3 == 3'd3) | (funct3 == 3'd6) | (funct3 == 3'd7);
        end
        if (funct3[1:0] == 2'b01) begin
            w_misaligned = ALUResult[0];
        end else if (funct3[1:0] == 2'b10) begin
            w_misaligned = (ALUResult[1:0] != 2'b00);
        end
    end

    // Store lane replication and byte enables.
    always_comb begin
        w_st_wdata = ReadData2;
        w_st_be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                w_st_wdata = {4{ReadData2[7:0]}};
                w_st_be    = 4'b0001 << ALUResult[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{ReadData2[15:0]}};
                w_st_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_wdata = ReadData2;
                w_st_be    = 4'b1111;
            end
        endcase
    end

    // Extract and extend the addressed lane of the returned read word.
    always_comb begin
        logic [31:0] v_sh;
        logic [15:0] v_half;
        v_sh   = mem_rdata >> {r_off, 3'b000};
        v_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'd0:    w_ld_fmt = {{24{v_sh[7]}}, v_sh[7:0]};
            3'd4:    w_ld_fmt = {24'd0, v_sh[7:0]};
            3'd1:    w_ld_fmt = {{16{v_half[15]}}, v_half};
            3'd5:    w_ld_fmt = {16'd0, v_half};
            default: w_ld_fmt = mem_rdata;
        endcase
    end

    // Access FSM: accept in IDLE, hold the memory request in REQ, pulse done in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_off       <= '0;
            r_funct3    <= '0;
            r_is_load   <= 1'b0;
            r_load_data <= '0;
            r_fault     <= F_OK;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_off     <= ALUResult[1:0];
                        r_funct3  <= funct3;
                        r_is_load <= ~MemWrite;
                        r_cnt     <= '0;
                        if (w_illegal) begin
                            r_fault     <= F_ILL;
                            r_load_data <= '0;
                            r_state     <= S_RESP;
                        end else if (w_misaligned) begin
                            r_fault     <= F_ALIGN;
                            r_load_data <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= MemWrite;
                            r_mem_addr  <= ALUResult[ADDR_WIDTH+1:2];
                            r_mem_wdata <= w_st_wdata;
                            r_mem_be    <= MemWrite ? w_st_be : 4'b0000;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_fault     <= F_OK;
                        r_load_data <= r_is_load ? w_ld_fmt : 32'd0;
                        r_cnt       <= '0;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_mem_req   <= 1'b0;
                        r_fault     <= F_TMO;
                        r_load_data <= '0;
                        r_cnt       <= '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_RESP);
    assign load_data = r_load_data;
    assign fault     = r_fault;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, corner-case sequences,
// and randomized accesses checked against a byte-addressed reference memory.
module tb_mem_access_unit;

    localparam int AW = 14;
    localparam int TO = 16;
    localparam int NWORDS = 1 << AW;
    localparam int NBYTES = 1 << (AW + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, MemRead, MemWrite;
    logic [2:0]    funct3;
    logic [31:0]   ALUResult, ReadData2;
    logic          busy, done;
    logic [31:0]   load_data;
    logic [1:0]    fault;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata = 32'd0;
    logic          mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .funct3(funct3), .ALUResult(ALUResult),
        .ReadData2(ReadData2), .busy(busy), .done(done), .load_data(load_data),
        .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    logic [31:0] mem [0:NWORDS-1];
    logic [7:0]  ref_b [0:NBYTES-1];

    int checks = 0;
    int errors = 0;

    int ack_lat = 0;
    int wcnt = 0;
    bit hold_ack = 1'b0;
    bit force_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_lat idle REQ cycles, applies writes per byte enable.
    always @(negedge clk) begin
        if (force_ack) begin
            mem_ack = 1'b1;
        end else if (rst || !mem_req) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (!hold_ack) begin
            if (wcnt >= ack_lat) begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we) begin
                    for (int j = 0; j < 4; j++)
                        if (mem_be[j]) mem[mem_addr][8*j +: 8] = mem_wdata[8*j +: 8];
                end
            end else begin
                wcnt++;
            end
        end
    end

    // Reference: access size from funct3, natural alignment rule, little-endian bytes.
    function automatic void ref_model(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] rs2,
                                      output logic [1:0] flt, output logic [31:0] ld,
                                      output logic [3:0] be, output logic [31:0] wd,
                                      output logic [AW-1:0] wa);
        int unsigned size;
        int unsigned base;
        int unsigned lane;
        flt = 2'b00; ld = 32'd0; be = 4'd0; wd = 32'd0;
        wa = addr[AW+1:2];
        size = 0;
        if (wr) begin
            if (f3 == 3'd0) size = 1;
            else if (f3 == 3'd1) size = 2;
            else if (f3 == 3'd2) size = 4;
        end else if (rd) begin
            if (f3 == 3'd0 || f3 == 3'd4) size = 1;
            else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
            else if (f3 == 3'd2) size = 4;
        end
        if (size == 0) begin
            flt = 2'b10;
        end else if ((addr % size) != 0) begin
            flt = 2'b01;
        end else begin
            base = addr % NBYTES;
            lane = addr % 4;
            if (wr) begin
                for (int unsigned j = 0; j < 4; j++) wd[8*j +: 8] = rs2[8*(j % size) +: 8];
                for (int unsigned k = 0; k < size; k++) begin
                    ref_b[base + k] = rs2[8*k +: 8];
                    be[lane + k] = 1'b1;
                end
            end else begin
                for (int unsigned k = 0; k < size; k++)
                    ld = ld | ({24'd0, ref_b[base + k]} << (8*k));
                if (f3 < 3'd4 && size < 4 && ld[8*size-1])
                    ld = ld | (32'hFFFF_FFFF << (8*size));
            end
        end
    endfunction

    // Issue one request, then observe the DUT each cycle until done or maxk cycles pass.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input int lat, input int maxk,
                          output int done_k, output int req_k, output int busy_k,
                          output logic [31:0] ld, output logic [31:0] ld_after,
                          output logic [1:0] flt, output logic done_after,
                          output logic [AW-1:0] ma, output logic mwe,
                          output logic [3:0] mbe, output logic [31:0] mwd,
                          output logic stable);
        ack_lat = lat;
        req_valid = 1'b1; MemRead = rd; MemWrite = wr;
        funct3 = f3; ALUResult = addr; ReadData2 = rs2;
        @(negedge clk);
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        ALUResult = $urandom; ReadData2 = $urandom; funct3 = 3'($urandom);
        done_k = -1; req_k = 0; busy_k = 0;
        ld = 32'hX; ld_after = 32'hX; flt = 2'bxx; done_after = 1'bx;
        ma = '0; mwe = 1'b0; mbe = '0; mwd = '0; stable = 1'b1;
        for (int k = 1; k <= maxk; k++) begin
            if (mem_req) begin
                req_k++;
                if (req_k == 1) begin
                    ma = mem_addr; mwe = mem_we; mbe = mem_be; mwd = mem_wdata;
                end else if (ma !== mem_addr || mwe !== mem_we || mbe !== mem_be || mwd !== mem_wdata) begin
                    stable = 1'b0;
                end
            end
            if (busy) busy_k++;
            if (done) begin
                done_k = k; ld = load_data; flt = fault;
                @(negedge clk);
                done_after = done; ld_after = load_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_check(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rs2, input int lat,
                             input logic [1:0] eflt, input logic [31:0] eld,
                             input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic [AW-1:0] ewa);
        int dk, rk, bk;
        logic [31:0] ld, lda, mwd;
        logic [1:0] flt;
        logic da, mwe, st;
        logic [AW-1:0] ma;
        logic [3:0] mbe;
        bit faulted;
        if (!rd && !wr) begin
            access(rd, wr, f3, addr, rs2, lat, 5, dk, rk, bk, ld, lda, flt, da, ma, mwe, mbe, mwd, st);
            chk({tag, ".nodone"}, dk, 32'hFFFF_FFFF);
            chk({tag, ".noreq"}, rk, 0);
            chk({tag, ".nobusy"}, bk, 0);
            return;
        end
        access(rd, wr, f3, addr, rs2, lat, 40, dk, rk, bk, ld, lda, flt, da, ma, mwe, mbe, mwd, st);
        faulted = (eflt != 2'b00);
        chk({tag, ".done_cyc"}, dk, faulted ? 1 : lat + 2);
        chk({tag, ".req_cyc"}, rk, faulted ? 0 : lat + 1);
        chk({tag, ".busy_cyc"}, bk, faulted ? 1 : lat + 2);
        chk({tag, ".fault"}, {30'd0, flt}, {30'd0, eflt});
        chk({tag, ".load_data"}, ld, eld);
        chk({tag, ".load_hold"}, lda, eld);
        chk({tag, ".done_pulse"}, {31'd0, da}, 32'd0);
        if (!faulted) begin
            chk({tag, ".mem_addr"}, {{(32-AW){1'b0}}, ma}, {{(32-AW){1'b0}}, ewa});
            chk({tag, ".mem_we"}, {31'd0, mwe}, {31'd0, wr});
            chk({tag, ".mem_be"}, {28'd0, mbe}, {28'd0, ebe});
            chk({tag, ".stable"}, {31'd0, st}, 32'd1);
            if (wr) chk({tag, ".mem_wdata"}, mwd, ewd);
        end
    endtask

    typedef struct {
        logic          rd, wr;
        logic [2:0]    f3;
        logic [31:0]   addr, rs2;
        int            lat;
        logic [1:0]    flt;
        logic [31:0]   ld;
        logic [3:0]    be;
        logic [31:0]   wd;
        logic [AW-1:0] wa;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rs2, input int lat,
                                input logic [1:0] flt, input logic [31:0] ld,
                                input logic [3:0] be, input logic [31:0] wd, input int wa);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.lat = lat;
        v.flt = flt; v.ld = ld; v.be = be; v.wd = wd; v.wa = AW'(wa);
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        logic [1:0] mflt;
        logic [31:0] mld, mwd;
        logic [3:0] mbe;
        logic [AW-1:0] mwa;
        int dk, rk, bk, ndone;
        logic [31:0] ld, lda, wd_o;
        logic [1:0] flt;
        logic da, we_o, st, we_seen;
        logic [AW-1:0] ma;
        logic [3:0] be_o;

        for (int i = 0; i < NWORDS; i++) mem[i] = (i * 32'h0100_0193) ^ 32'hC3A5_5A3C;
        mem[5] = 32'h8000_80F0;
        mem[8] = 32'h0000_0000;
        for (int i = 0; i < NWORDS; i++)
            for (int j = 0; j < 4; j++) ref_b[4*i + j] = mem[i][8*j +: 8];

        tbl[0]  = mk(1, 0, 3'd0, 32'h15, 0, 0, 2'b00, 32'hFFFF_FF80, 4'b0000, 0, 5);
        tbl[1]  = mk(1, 0, 3'd4, 32'h15, 0, 1, 2'b00, 32'h0000_0080, 4'b0000, 0, 5);
        tbl[2]  = mk(1, 0, 3'd1, 32'h16, 0, 0, 2'b00, 32'hFFFF_8000, 4'b0000, 0, 5);
        tbl[3]  = mk(1, 0, 3'd5, 32'h14, 0, 2, 2'b00, 32'h0000_80F0, 4'b0000, 0, 5);
        tbl[4]  = mk(1, 0, 3'd2, 32'h14, 0, 0, 2'b00, 32'h8000_80F0, 4'b0000, 0, 5);
        tbl[5]  = mk(0, 1, 3'd1, 32'h22, 32'h1234_ABCD, 0, 2'b00, 0, 4'b1100, 32'hABCD_ABCD, 8);
        tbl[6]  = mk(1, 0, 3'd2, 32'h20, 0, 0, 2'b00, 32'hABCD_0000, 4'b0000, 0, 8);
        tbl[7]  = mk(1, 0, 3'd2, 32'h102, 0, 0, 2'b01, 0, 4'b0000, 0, 0);
        tbl[8]  = mk(1, 0, 3'd5, 32'h101, 0, 0, 2'b01, 0, 4'b0000, 0, 0);
        tbl[9]  = mk(1, 0, 3'd3, 32'h40, 0, 0, 2'b10, 0, 4'b0000, 0, 0);
        tbl[10] = mk(0, 1, 3'd4, 32'h40, 32'h1111_1111, 0, 2'b10, 0, 4'b0000, 0, 0);
        tbl[11] = mk(0, 1, 3'd0, 32'h33, 32'hA5A5_A55A, 0, 2'b00, 0, 4'b1000, 32'h5A5A_5A5A, 12);
        tbl[12] = mk(1, 0, 3'd0, 32'h33, 0, 0, 2'b00, 32'h0000_005A, 4'b0000, 0, 12);
        tbl[13] = mk(1, 0, 3'd2, 32'h0001_0014, 0, 0, 2'b00, 32'h8000_80F0, 4'b0000, 0, 5);
        tbl[14] = mk(0, 1, 3'd2, 32'h40, 32'hDEAD_BEEF, 1, 2'b00, 0, 4'b1111, 32'hDEAD_BEEF, 16);
        tbl[15] = mk(1, 0, 3'd2, 32'h40, 0, 3, 2'b00, 32'hDEAD_BEEF, 4'b0000, 0, 16);
        tbl[16] = mk(1, 1, 3'd2, 32'h44, 32'h0BAD_F00D, 0, 2'b00, 0, 4'b1111, 32'h0BAD_F00D, 17);
        tbl[17] = mk(0, 1, 3'd1, 32'h23, 32'h5555_5555, 0, 2'b01, 0, 4'b0000, 0, 0);

        rst = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'd0; ALUResult = 32'd0; ReadData2 = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 0);
        chk("rst.done", {31'd0, done}, 0);
        chk("rst.mem_req", {31'd0, mem_req}, 0);
        chk("rst.mem_we", {31'd0, mem_we}, 0);
        chk("rst.mem_be", {28'd0, mem_be}, 0);
        chk("rst.load_data", load_data, 0);
        chk("rst.fault", {30'd0, fault}, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            ref_model(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].rs2, mflt, mld, mbe, mwd, mwa);
            run_check($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr,
                      tbl[i].rs2, tbl[i].lat, tbl[i].flt, tbl[i].ld, tbl[i].be, tbl[i].wd, tbl[i].wa);
        end

        // Timeout: memory never acknowledges.
        hold_ack = 1'b1;
        access(1, 0, 3'd2, 32'h40, 0, 0, 40, dk, rk, bk, ld, lda, flt, da, ma, we_o, be_o, wd_o, st);
        hold_ack = 1'b0;
        chk("tmo.req_cyc", rk, TO);
        chk("tmo.done_cyc", dk, TO + 1);
        chk("tmo.fault", {30'd0, flt}, 32'd3);
        chk("tmo.load_data", ld, 0);
        chk("tmo.req_dropped", {31'd0, mem_req}, 0);

        // Second req_valid while busy must be ignored.
        ack_lat = 3;
        req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'd2; ALUResult = 32'h40;
        @(negedge clk);
        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'd2;
        ALUResult = 32'h40; ReadData2 = 32'h0;
        @(negedge clk);
        req_valid = 1'b0; MemWrite = 1'b0;
        ndone = 0; we_seen = 1'b0; ld = 32'd0;
        for (int k = 0; k < 12; k++) begin
            if (mem_req && mem_we) we_seen = 1'b1;
            if (done) begin ndone++; ld = load_data; end
            @(negedge clk);
        end
        chk("busyreq.ndone", ndone, 1);
        chk("busyreq.no_write", {31'd0, we_seen}, 0);
        chk("busyreq.load_data", ld, 32'hDEAD_BEEF);
        run_check("busyreq.readback", 1, 0, 3'd2, 32'h40, 0, 0, 2'b00, 32'hDEAD_BEEF, 4'b0000, 0, 16);

        // Reset while a request is outstanding; a late ack must not produce done.
        hold_ack = 1'b1;
        req_valid = 1'b1; MemRead = 1'b1; funct3 = 3'd2; ALUResult = 32'h14;
        @(negedge clk);
        req_valid = 1'b0; MemRead = 1'b0;
        @(negedge clk);
        chk("rstmid.in_req", {31'd0, mem_req}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid.mem_req", {31'd0, mem_req}, 0);
        chk("rstmid.busy", {31'd0, busy}, 0);
        chk("rstmid.done", {31'd0, done}, 0);
        chk("rstmid.load_data", load_data, 0);
        rst = 1'b0; hold_ack = 1'b0; force_ack = 1'b1;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        force_ack = 1'b0;
        @(negedge clk);
        chk("rstmid.late_ack", ndone, 0);
        run_check("rstmid.recover", 1, 0, 3'd4, 32'h15, 0, 0, 2'b00, 32'h0000_0080, 4'b0000, 0, 5);

        // Randomized accesses against the byte-level reference.
        for (int n = 0; n < 80; n++) begin
            int unsigned r;
            logic rd, wr;
            logic [2:0] f3;
            logic [31:0] addr, rs2;
            int lat;
            r = $urandom_range(0, 9);
            rd = (r >= 4);
            wr = (r >= 1 && r <= 4);
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (rd && !wr && $urandom_range(0, 1) == 1 && f3 < 3'd2) f3 = f3 + 3'd4;
            addr = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(f3[1:0] == 2'b10 ? 3 : (f3[1:0] == 2'b01 ? 1 : 0));
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_0000);
            rs2 = $urandom;
            lat = $urandom_range(0, 4);
            ref_model(rd, wr, f3, addr, rs2, mflt, mld, mbe, mwd, mwa);
            run_check($sformatf("rnd%0d", n), rd, wr, f3, addr, rs2, lat, mflt, mld, mbe, mwd, mwa);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
